axi_master_modport_checker: RTL and testbench

//  Passive AXI4 protocol checker and statistics block for one master port
//  (e.g. M3) of the 4-master/7-slave interconnect. It observes every master-port

---
 rtl/axi_master_modport_checker.sv | 208 ++++++++++++++++++++
 tb/tb_axi_master_modport_checker.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_modport_checker.sv
// axi_master_modport_checker
//   Passive AXI4 protocol checker and statistics block for one master port.
//   Watches every channel of the port, raises sticky violation flags and keeps
//   handshake and outstanding-transaction counts. Never drives the bus.
//
// Ports
//   ACLK, ARESETn         clock (posedge) and async active-low reset
//   clr_err               sync pulse, clears sticky error flags
//   AW*/W*/B*/AR*/R*      observed AXI4 channel signals (all inputs)
//   err_flags[9:0]        sticky violation bits
//     [0] AWVALID dropped before handshake   [5] AW payload changed while stalled
//     [1] WVALID dropped before handshake    [6] W payload changed while stalled
//     [2] ARVALID dropped before handshake   [7] AR payload changed while stalled
//     [3] BREADY dropped while waiting       [8] B handshake with no open write
//     [4] RREADY dropped while waiting       [9] R last beat with no open read
//   err_any               OR of err_flags
//   aw/w/b/ar/r_cnt       per-channel handshake counters (wrapping)
//   wr/rd_outstanding     open write/read transactions (saturating)
module axi_master_modport_checker #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int OUT_W  = 8
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                clr_err,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWLOCK,
  input  logic [3:0]          AWCACHE,
  input  logic [2:0]          AWPROT,
  input  logic [3:0]          AWQOS,
  input  logic [3:0]          AWREGION,
  input  logic [0:0]          AWUSER,
  input  logic                AWVALID,
  input  logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic [0:0]          WUSER,
  input  logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic [0:0]          BUSER,
  input  logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARLOCK,
  input  logic [3:0]          ARCACHE,
  input  logic [2:0]          ARPROT,
  input  logic [3:0]          ARQOS,
  input  logic [3:0]          ARREGION,
  input  logic [0:0]          ARUSER,
  input  logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic [0:0]          RUSER,
  input  logic                RVALID,
  input  logic                RREADY,
  output logic [9:0]          err_flags,
  output logic                err_any,
  output logic [CNT_W-1:0]    aw_cnt,
  output logic [CNT_W-1:0]    w_cnt,
  output logic [CNT_W-1:0]    b_cnt,
  output logic [CNT_W-1:0]    ar_cnt,
  output logic [CNT_W-1:0]    r_cnt,
  output logic [OUT_W-1:0]    wr_outstanding,
  output logic [OUT_W-1:0]    rd_outstanding
);

  localparam int A_PL_W = ID_W + ADDR_W + 25;
  localparam int W_PL_W = DATA_W + DATA_W/8 + 1;

  // USER bits and response payloads are not checked.
  logic unused_inputs;
  assign unused_inputs = ^{AWUSER, WUSER, BID, BRESP, BUSER, ARUSER,
                           RID, RDATA, RRESP, RUSER};

  logic [A_PL_W-1:0] aw_pl, ar_pl, aw_pl_q, ar_pl_q;
  logic [W_PL_W-1:0] w_pl, w_pl_q;

  assign aw_pl = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK,
                  AWCACHE, AWPROT, AWQOS, AWREGION};
  assign ar_pl = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK,
                  ARCACHE, ARPROT, ARQOS, ARREGION};
  assign w_pl  = {WDATA, WSTRB, WLAST};

  logic aw_v_q, aw_r_q, w_v_q, w_r_q, ar_v_q, ar_r_q;
  logic b_v_q, b_r_q, r_v_q, r_r_q;
  logic chk_en;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_hs;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign b_hs      = BVALID && BREADY;
  assign ar_hs     = ARVALID && ARREADY;
  assign r_hs      = RVALID && RREADY;
  assign r_last_hs = r_hs && RLAST;

  // Stalled = valid was presented last cycle without being accepted.
  logic aw_stall, w_stall, ar_stall;
  assign aw_stall = aw_v_q && !aw_r_q;
  assign w_stall  = w_v_q && !w_r_q;
  assign ar_stall = ar_v_q && !ar_r_q;

  logic [9:0] err_new, err_nxt;

  always_comb begin
    err_new = '0;
    if (chk_en) begin
      err_new[0] = aw_stall && !AWVALID;
      err_new[1] = w_stall && !WVALID;
      err_new[2] = ar_stall && !ARVALID;
      err_new[3] = b_r_q && !b_v_q && !BREADY;
      err_new[4] = r_r_q && !r_v_q && !RREADY;
      err_new[5] = aw_stall && AWVALID && (aw_pl != aw_pl_q);
      err_new[6] = w_stall && WVALID && (w_pl != w_pl_q);
      err_new[7] = ar_stall && ARVALID && (ar_pl != ar_pl_q);
      err_new[8] = b_hs && (wr_outstanding == '0);
      err_new[9] = r_last_hs && (rd_outstanding == '0);
    end
    // A violation seen in the same cycle as clr_err survives the clear.
    err_nxt = clr_err ? err_new : (err_flags | err_new);
  end

  logic [OUT_W-1:0] wr_nxt, rd_nxt;

  always_comb begin
    wr_nxt = wr_outstanding;
    if (aw_hs && !b_hs) begin
      if (wr_outstanding != '1) wr_nxt = wr_outstanding + OUT_W'(1);
    end else if (!aw_hs && b_hs) begin
      if (wr_outstanding != '0) wr_nxt = wr_outstanding - OUT_W'(1);
    end
    rd_nxt = rd_outstanding;
    if (ar_hs && !r_last_hs) begin
      if (rd_outstanding != '1) rd_nxt = rd_outstanding + OUT_W'(1);
    end else if (!ar_hs && r_last_hs) begin
      if (rd_outstanding != '0) rd_nxt = rd_outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      chk_en         <= 1'b0;
      aw_v_q         <= 1'b0;
      aw_r_q         <= 1'b0;
      w_v_q          <= 1'b0;
      w_r_q          <= 1'b0;
      ar_v_q         <= 1'b0;
      ar_r_q         <= 1'b0;
      b_v_q          <= 1'b0;
      b_r_q          <= 1'b0;
      r_v_q          <= 1'b0;
      r_r_q          <= 1'b0;
      aw_pl_q        <= '0;
      ar_pl_q        <= '0;
      w_pl_q         <= '0;
      err_flags      <= '0;
      err_any        <= 1'b0;
      aw_cnt         <= '0;
      w_cnt          <= '0;
      b_cnt          <= '0;
      ar_cnt         <= '0;
      r_cnt          <= '0;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
    end else begin
      chk_en         <= 1'b1;
      aw_v_q         <= AWVALID;
      aw_r_q         <= AWREADY;
      w_v_q          <= WVALID;
      w_r_q          <= WREADY;
      ar_v_q         <= ARVALID;
      ar_r_q         <= ARREADY;
      b_v_q          <= BVALID;
      b_r_q          <= BREADY;
      r_v_q          <= RVALID;
      r_r_q          <= RREADY;
      aw_pl_q        <= aw_pl;
      ar_pl_q        <= ar_pl;
      w_pl_q         <= w_pl;
      err_flags      <= err_nxt;
      err_any        <= |err_nxt;
      if (aw_hs) aw_cnt <= aw_cnt + CNT_W'(1);
      if (w_hs)  w_cnt  <= w_cnt + CNT_W'(1);
      if (b_hs)  b_cnt  <= b_cnt + CNT_W'(1);
      if (ar_hs) ar_cnt <= ar_cnt + CNT_W'(1);
      if (r_hs)  r_cnt  <= r_cnt + CNT_W'(1);
      wr_outstanding <= wr_nxt;
      rd_outstanding <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_axi_master_modport_checker.sv
module tb_axi_master_modport_checker;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        clr_err;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic [3:0]  AWQOS;
  logic [3:0]  AWREGION;
  logic [0:0]  AWUSER;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic [0:0]  WUSER;
  logic        WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic [0:0]  BUSER;
  logic        BVALID, BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [3:0]  ARQOS;
  logic [3:0]  ARREGION;
  logic [0:0]  ARUSER;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic [0:0]  RUSER;
  logic        RVALID, RREADY;
  logic [9:0]  err_flags;
  logic        err_any;
  logic [15:0] aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [7:0]  wr_outstanding, rd_outstanding;

  always #5 ACLK = ~ACLK;

  axi_master_modport_checker dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .clr_err(clr_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWQOS(AWQOS), .AWREGION(AWREGION), .AWUSER(AWUSER),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARQOS(ARQOS), .ARREGION(ARREGION), .ARUSER(ARUSER),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
    .RVALID(RVALID), .RREADY(RREADY),
    .err_flags(err_flags), .err_any(err_any),
    .aw_cnt(aw_cnt), .w_cnt(w_cnt), .b_cnt(b_cnt), .ar_cnt(ar_cnt), .r_cnt(r_cnt),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    clr_err = 0;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWLOCK = 0;
    AWCACHE = 0; AWPROT = 0; AWQOS = 0; AWREGION = 0; AWUSER = 0;
    AWVALID = 0; AWREADY = 0;
    WDATA = 0; WSTRB = 0; WLAST = 0; WUSER = 0; WVALID = 0; WREADY = 0;
    BID = 0; BRESP = 0; BUSER = 0; BVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARLOCK = 0;
    ARCACHE = 0; ARPROT = 0; ARQOS = 0; ARREGION = 0; ARUSER = 0;
    ARVALID = 0; ARREADY = 0;
    RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RUSER = 0; RVALID = 0; RREADY = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESETn = 0;
    tick();
    tick();
    ARESETn = 1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_err"}, 32'(err_flags), 0);
    chk({tag, "_any"}, 32'(err_any), 0);
    chk({tag, "_awc"}, 32'(aw_cnt), 0);
    chk({tag, "_wc"},  32'(w_cnt), 0);
    chk({tag, "_bc"},  32'(b_cnt), 0);
    chk({tag, "_arc"}, 32'(ar_cnt), 0);
    chk({tag, "_rc"},  32'(r_cnt), 0);
    chk({tag, "_wro"}, 32'(wr_outstanding), 0);
    chk({tag, "_rdo"}, 32'(rd_outstanding), 0);
  endtask

  // bits: aw_v aw_r w_v w_r wlast b_v b_r ar_v ar_r r_v r_r rlast
  typedef struct {
    logic [11:0] in_bits;
    logic [7:0]  exp_wr;
    logic [7:0]  exp_rd;
    logic [9:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] aw, w, b, ar, r;
    logic [7:0]  wr, rd;
    logic [9:0]  err;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  initial begin
    exp_t e;
    logic [15:0] m_aw, m_w, m_b, m_ar, m_r;

    vecs[0]  = '{12'b110000000000, 8'd1, 8'd0, 10'h000};
    vecs[1]  = '{12'b000000011000, 8'd1, 8'd1, 10'h000};
    vecs[2]  = '{12'b000000011110, 8'd1, 8'd2, 10'h000};
    vecs[3]  = '{12'b110001100000, 8'd1, 8'd2, 10'h000};
    vecs[4]  = '{12'b001111100000, 8'd0, 8'd2, 10'h000};
    vecs[5]  = '{12'b000000000111, 8'd0, 8'd1, 10'h000};
    vecs[6]  = '{12'b000000000111, 8'd0, 8'd0, 10'h000};
    vecs[7]  = '{12'b000001100000, 8'd0, 8'd0, 10'h100};
    vecs[8]  = '{12'b000000000111, 8'd0, 8'd0, 10'h300};
    vecs[9]  = '{12'b000000000000, 8'd0, 8'd0, 10'h300};
    vecs[10] = '{12'b100000000000, 8'd0, 8'd0, 10'h300};
    vecs[11] = '{12'b000000000000, 8'd0, 8'd0, 10'h301};

    // Reset held: inputs toggle, outputs must stay at zero.
    idle_inputs();
    ARESETn = 0;
    for (int i = 0; i < 4; i++) begin
      AWVALID = 1; AWREADY = 1; WVALID = 1; WREADY = 1; WLAST = 1;
      BVALID = 1; BREADY = 1; ARVALID = 1; ARREADY = 1;
      RVALID = 1; RREADY = 1; RLAST = 1; clr_err = 1;
      AWADDR = $urandom; ARADDR = $urandom;
      tick();
      idle_inputs();
      tick();
    end
    chk_all_zero("rst");

    // Table-driven mixed traffic with scoreboard.
    do_reset();
    m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
    for (int i = 0; i < 12; i++) begin
      logic [11:0] v;
      v = vecs[i].in_bits;
      {AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY,
       ARVALID, ARREADY, RVALID, RREADY, RLAST} = v;
      if (v[11] && v[10]) m_aw++;
      if (v[9] && v[8])   m_w++;
      if (v[6] && v[5])   m_b++;
      if (v[4] && v[3])   m_ar++;
      if (v[2] && v[1])   m_r++;
      e.aw = m_aw; e.w = m_w; e.b = m_b; e.ar = m_ar; e.r = m_r;
      e.wr = vecs[i].exp_wr; e.rd = vecs[i].exp_rd; e.err = vecs[i].exp_err;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_awc", i), 32'(aw_cnt), 32'(e.aw));
      chk($sformatf("vec%0d_wc", i),  32'(w_cnt),  32'(e.w));
      chk($sformatf("vec%0d_bc", i),  32'(b_cnt),  32'(e.b));
      chk($sformatf("vec%0d_arc", i), 32'(ar_cnt), 32'(e.ar));
      chk($sformatf("vec%0d_rc", i),  32'(r_cnt),  32'(e.r));
      chk($sformatf("vec%0d_wro", i), 32'(wr_outstanding), 32'(e.wr));
      chk($sformatf("vec%0d_rdo", i), 32'(rd_outstanding), 32'(e.rd));
      chk($sformatf("vec%0d_err", i), 32'(err_flags), 32'(e.err));
      chk($sformatf("vec%0d_any", i), 32'(err_any), 32'(e.err != 0));
    end

    // AW held legally for 3 stalled cycles, then accepted.
    do_reset();
    AWVALID = 1; AWADDR = 32'h40;
    repeat (3) tick();
    AWREADY = 1;
    tick();
    AWVALID = 0; AWREADY = 0;
    tick();
    chk("awhold_cnt", 32'(aw_cnt), 1);
    chk("awhold_wro", 32'(wr_outstanding), 1);
    chk("awhold_err", 32'(err_flags), 0);

    // AWVALID withdrawn, then clr_err.
    do_reset();
    AWVALID = 1;
    tick();
    AWVALID = 0;
    tick();
    chk("awdrop_err", 32'(err_flags), 32'h001);
    chk("awdrop_any", 32'(err_any), 1);
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("clr_err", 32'(err_flags), 0);
    chk("clr_any", 32'(err_any), 0);

    // clr_err coinciding with a new violation: old flag cleared, new kept.
    ARVALID = 1;
    tick();
    ARVALID = 0;
    tick();
    chk("ardrop_err", 32'(err_flags), 32'h004);
    AWVALID = 1;
    tick();
    AWVALID = 0; clr_err = 1;
    tick();
    clr_err = 0;
    chk("clr_vs_new", 32'(err_flags), 32'h001);

    // AR payload change while stalled.
    do_reset();
    ARVALID = 1; ARADDR = 32'h1000;
    tick();
    ARADDR = 32'h2000;
    tick();
    chk("arpl_err", 32'(err_flags), 32'h080);
    ARREADY = 1;
    tick();
    ARVALID = 0; ARREADY = 0;
    tick();
    chk("arpl_sticky", 32'(err_flags), 32'h080);

    // W payload change while stalled.
    do_reset();
    WVALID = 1; WDATA = 32'hA5A5_0000; WSTRB = 4'hF;
    tick();
    WSTRB = 4'h3;
    tick();
    chk("wpl_err", 32'(err_flags), 32'h040);

    // Full write transaction then an unexpected extra B.
    do_reset();
    AWVALID = 1; AWREADY = 1; AWLEN = 4'd3;
    tick();
    AWVALID = 0; AWREADY = 0;
    for (int b = 0; b < 4; b++) begin
      WVALID = 1; WREADY = 1; WDATA = 32'h100 + 32'(b); WSTRB = 4'hF;
      WLAST = (b == 3);
      tick();
    end
    WVALID = 0; WREADY = 0; WLAST = 0;
    chk("wr_mid_wro", 32'(wr_outstanding), 1);
    BVALID = 1; BREADY = 1;
    tick();
    BVALID = 0; BREADY = 0;
    tick();
    chk("wr_wc", 32'(w_cnt), 4);
    chk("wr_bc", 32'(b_cnt), 1);
    chk("wr_wro", 32'(wr_outstanding), 0);
    chk("wr_err", 32'(err_flags), 0);
    BVALID = 1; BREADY = 1;
    tick();
    BVALID = 0; BREADY = 0;
    chk("wr_xb_err", 32'(err_flags), 32'h100);
    chk("wr_xb_wro", 32'(wr_outstanding), 0);

    // AR and last R beat in one cycle with one read open.
    do_reset();
    ARVALID = 1; ARREADY = 1;
    tick();
    RVALID = 1; RREADY = 1; RLAST = 1;
    tick();
    ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
    chk("sim_rdo", 32'(rd_outstanding), 1);
    chk("sim_rc", 32'(r_cnt), 1);
    chk("sim_arc", 32'(ar_cnt), 2);
    chk("sim_err", 32'(err_flags), 0);

    // Outstanding count saturates at all-ones; handshake count keeps going.
    do_reset();
    AWVALID = 1; AWREADY = 1;
    repeat (256) tick();
    AWVALID = 0; AWREADY = 0;
    chk("sat_wro", 32'(wr_outstanding), 255);
    chk("sat_awc", 32'(aw_cnt), 256);

    // BREADY withdrawn while waiting for a response.
    do_reset();
    BREADY = 1;
    tick();
    BREADY = 0;
    tick();
    chk("bready_err", 32'(err_flags), 32'h008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
